// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-look-ahead adder/subtractor with status flags.
// The WIDTH-bit operation is split into NSEG = WIDTH/SEG_W segments. Each
// segment is one pipeline stage: it adds its SEG_W-bit slice with a group
// look-ahead carry network, using the carry registered by the previous stage.
// Unprocessed operand slices travel down the pipe with the beat. Each stage
// passes on only the slices still waiting to be added, so the pending operand
// storage shrinks from stage to stage. Finished sum slices are carried forward
// in their final bit positions.
//
// Handshake (valid/ready): a beat moves across an interface exactly in a cycle
// where both valid and ready are high at the rising clock edge. Once out_valid
// is raised, the result and its flags stay stable until out_ready takes it.
// The whole pipe shifts as one unit when advance = !out_valid || out_ready.
// in_ready equals advance, so a result can leave and a new beat can enter in
// the same cycle.
module cla_pipe_addsub #(
    parameter int WIDTH = 16,
    parameter int SEG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             carry,
    output logic             zero,
    output logic             parity,
    output logic             sign,
    output logic             overflow
);

    localparam int NSEG = WIDTH / SEG_W;
    // Total pending-operand bits over all stage boundaries (each operand).
    localparam int PEND_T = SEG_W * NSEG * (NSEG - 1) / 2;
    localparam int PEND_W = (PEND_T > 0) ? PEND_T : 1;

    // Bit offset of the pending slices written by stage k. Stage k forwards
    // WIDTH-(k+1)*SEG_W bits.
    function automatic int pend_off(input int k);
        int o;
        o = 0;
        for (int j = 0; j < k; j++) begin
            o += WIDTH - (j + 1) * SEG_W;
        end
        return o;
    endfunction

    // One SEG_W-bit group: every carry is expanded directly from generate and
    // propagate terms and the group carry-in, with no ripple between bits.
    // The function returns {carry_out, sum}.
    function automatic logic [SEG_W:0] cla_seg(
        input logic [SEG_W-1:0] a,
        input logic [SEG_W-1:0] b,
        input logic             ci
    );
        logic [SEG_W-1:0] g;
        logic [SEG_W-1:0] p;
        logic [SEG_W:0]   c;
        logic             term;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < SEG_W; i++) begin
            c[i+1] = g[i];
            term   = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (term & g[j]);
                term   = term & p[j];
            end
            c[i+1] = c[i+1] | (term & ci);
        end
        return {c[SEG_W], p ^ c[SEG_W-1:0]};
    endfunction

    // Stage registers (_q) and their next values (_n).
    logic [NSEG-1:0]            v_q, v_n;
    logic [NSEG-1:0]            c_q, c_n;
    logic [NSEG-1:0][WIDTH-1:0] s_q, s_n;
    logic [PEND_W-1:0]          pa_q, pa_n;
    logic [PEND_W-1:0]          pb_q, pb_n;
    logic                       ov_q, ov_n;
    logic                       advance;

    assign advance  = !v_q[NSEG-1] || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam int WIN = WIDTH - k * SEG_W;

        logic [WIN-1:0]   a_in;
        logic [WIN-1:0]   b_in;
        logic             c_in;
        logic [WIDTH-1:0] s_in;
        logic [SEG_W:0]   r;

        if (k == 0) begin : g_first
            // Subtraction becomes x + ~y + 1. In that mode cin is ignored.
            assign a_in   = x;
            assign b_in   = sub ? ~y : y;
            assign c_in   = sub ? 1'b1 : cin;
            assign s_in   = '0;
            assign v_n[0] = in_valid;
        end else begin : g_next
            assign a_in   = pa_q[pend_off(k-1) +: WIN];
            assign b_in   = pb_q[pend_off(k-1) +: WIN];
            assign c_in   = c_q[k-1];
            assign s_in   = s_q[k-1];
            assign v_n[k] = v_q[k-1];
        end

        assign r      = cla_seg(a_in[SEG_W-1:0], b_in[SEG_W-1:0], c_in);
        assign c_n[k] = r[SEG_W];
        // Bits at and above this slice are still zero in s_in.
        assign s_n[k] = s_in | (WIDTH'(r[SEG_W-1:0]) << (k * SEG_W));

        if (k < NSEG - 1) begin : g_pend
            assign pa_n[pend_off(k) +: WIN-SEG_W] = a_in[WIN-1:SEG_W];
            assign pb_n[pend_off(k) +: WIN-SEG_W] = b_in[WIN-1:SEG_W];
        end else begin : g_last
            // Signed overflow: the operands agree in sign but the result does not.
            assign ov_n = (a_in[SEG_W-1] == b_in[SEG_W-1]) &&
                          (r[SEG_W-1] != a_in[SEG_W-1]);
        end
    end

    // Pipeline registers: the pipe shifts as a whole on advance and is frozen
    // while the output is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q  <= '0;
            c_q  <= '0;
            s_q  <= '0;
            pa_q <= '0;
            pb_q <= '0;
            ov_q <= 1'b0;
        end else if (advance) begin
            v_q  <= v_n;
            c_q  <= c_n;
            s_q  <= s_n;
            pa_q <= pa_n;
            pb_q <= pb_n;
            ov_q <= ov_n;
        end
    end

    // Flags are derived from the final stage register. zero is qualified by
    // out_valid, so it reads 0 out of reset even though z is 0.
    assign out_valid = v_q[NSEG-1];
    assign z         = s_q[NSEG-1];
    assign carry     = c_q[NSEG-1];
    assign zero      = out_valid && (s_q[NSEG-1] == '0);
    assign parity    = ^s_q[NSEG-1];
    assign sign      = s_q[NSEG-1][WIDTH-1];
    assign overflow  = ov_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Testbench for cla_pipe_addsub (WIDTH=16, SEG_W=4, latency 4).
module tb_cla_pipe_addsub;

    localparam int W   = 16;
    localparam int SW  = 4;
    localparam int LAT = 4;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] z;
    logic         carry;
    logic         zero;
    logic         parity;
    logic         sign;
    logic         overflow;

    always #5 clk = ~clk;

    cla_pipe_addsub #(.WIDTH(W), .SEG_W(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .carry     (carry),
        .zero      (zero),
        .parity    (parity),
        .sign      (sign),
        .overflow  (overflow)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit mon_en   = 0;
    bit rand_rdy = 0;
    bit stalled  = 0;

    logic [20:0] exp_q[$];
    int          pop_cyc[$];
    logic [20:0] snap;
    logic [20:0] obs;

    assign obs = {overflow, sign, parity, zero, carry, z};

    always @(posedge clk) cyc++;

    // Downstream readiness: always ready, or pseudo-random when enabled.
    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        else          out_ready = 1'b1;
    end

    // ---------------- check / model ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference result packed as {ovf, sign, parity, zero, carry, z}.
    function automatic logic [20:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic ci, input logic s);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic [W-1:0] r;
        logic         ov;
        bb   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (s ? 1'b1 : ci)};
        r    = full[W-1:0];
        ov   = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
        return {ov, r[W-1], ^r, (r == '0), full[W], r};
    endfunction

    // ---------------- driver tasks ----------------
    // Called shortly after a rising edge; returns 1 time unit after the
    // accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic s);
        logic ok;
        int   n;
        x = a; y = b; cin = ci; sub = s; in_valid = 1'b1;
        n = 0;
        ok = 1'b0;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            if (ok) break;
            n++;
            if (n > 100) break;
        end
        if (ok) exp_q.push_back(model(a, b, ci, s));
        else    check("accept_timeout", 32'(n), 32'd0);
        #1 in_valid = 1'b0;
    endtask

    // Counts edges from the accepting edge until out_valid is seen.
    task automatic send_lat(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci, input logic s);
        int edges;
        send(a, b, ci, s);
        edges = 1;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            edges++;
            if (edges > 20) break;
        end
        check(tag, 32'(edges), 32'(LAT));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (stalled) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold", 32'(obs), 32'(snap));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    check("result", 32'(obs), 32'(exp_q.pop_front()));
                    pop_cyc.push_back(cyc);
                end
                stalled = 0;
            end else if (out_valid) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                snap    = obs;
                stalled = 1;
            end else begin
                stalled = 0;
            end
        end else begin
            stalled = 0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_outputs", 32'(obs), 32'd0);
        mon_en = 1;
        @(posedge clk);
        #1;

        // 1: basic add with latency.
        send_lat("latency_first", 16'h00FF, 16'hFF00, 1'b0, 1'b0);
        drain();

        // 2: back-to-back beats leave on consecutive cycles.
        pop_cyc.delete();
        send(16'h0F0F, 16'hF0F0, 1'b0, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        drain();
        check("b2b_count", 32'(pop_cyc.size()), 32'd2);
        if (pop_cyc.size() >= 2) check("b2b_gap", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);

        // 3: wrap-around with and without carry-in.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b1, 1'b0);
        // 4: subtraction cases.
        send(16'h0005, 16'h0005, 1'b0, 1'b1);
        send(16'h0003, 16'h0005, 1'b1, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        drain();

        // 5: incrementing stream with random backpressure.
        rand_rdy = 1;
        for (int i = 0; i < 8; i++) begin
            send(16'(16'h1000 + i), 16'($urandom_range(0, 65535)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();
        rand_rdy = 0;
        @(posedge clk);
        #1;
        drain();

        // 6: reset with three beats in flight.
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        send(16'h3333, 16'h4444, 1'b1, 1'b0);
        send(16'h5555, 16'h0101, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (8) begin
            @(negedge clk);
            check("post_rst_idle", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send_lat("latency_after_rst", 16'hABCD, 16'h1234, 1'b1, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
